// File: rtl/iseq_dispatcher_nlane.sv
// N-lane instruction-sequence front end: drains FWFT instruction FIFOs into per-lane
// one-entry valid/ack registers with RUN/DRAIN/abort control. Optional lane mask: ISEQ_LANE_MASK_EN.
module iseq_dispatcher_nlane #(
  parameter int N_LANES = 2,
  parameter int INSTR_W = 32,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       process_iseq,
  input  logic                       abort,
  output logic                       dispatcher_busy,
  output logic                       iseq_done,
  output logic [CNT_W-1:0]           issued_cnt,
  input  logic [N_LANES-1:0]         fifo_empty,
  input  logic [N_LANES*INSTR_W-1:0] fifo_data,
  output logic [N_LANES-1:0]         fifo_rd,
  output logic [N_LANES-1:0]         instr_valid,
  output logic [N_LANES*INSTR_W-1:0] instr_data,
  input  logic [N_LANES-1:0]         instr_ack
`ifdef ISEQ_LANE_MASK_EN
  ,
  input  logic [N_LANES-1:0]         lane_mask
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic                       w_done_nxt;
  logic                       r_busy;
  logic                       r_done;
  logic [CNT_W-1:0]           r_cnt;
  logic [N_LANES-1:0]         r_valid;
  logic [N_LANES*INSTR_W-1:0] r_data;
  logic [N_LANES-1:0]         w_lane_en;
  logic [N_LANES-1:0]         w_empty;
  logic [N_LANES-1:0]         w_rd;
  logic                       w_active;

  function automatic logic [3:0] popcnt(input logic [N_LANES-1:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < N_LANES; i++) c = c + 4'(v[i]);
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [3:0] b);
    logic [CNT_W+3:0] s;
    s = {4'b0, a} + (CNT_W+4)'(b);
    if (s > {4'b0, {CNT_W{1'b1}}}) return {CNT_W{1'b1}};
    return s[CNT_W-1:0];
  endfunction

`ifdef ISEQ_LANE_MASK_EN
  logic [N_LANES-1:0] r_mask;
  always_ff @(posedge clk) begin
    if (rst) r_mask <= '1;
    else if (r_state == S_IDLE && process_iseq) r_mask <= lane_mask;
  end
  assign w_lane_en = r_mask;
`else
  assign w_lane_en = '1;
`endif

  // Disabled lanes look permanently empty so they never hold up RUN->DRAIN->IDLE.
  assign w_empty  = fifo_empty | ~w_lane_en;
  assign w_active = (r_state != S_IDLE);

  always_comb begin
    w_rd = '0;
    for (int i = 0; i < N_LANES; i++)
      w_rd[i] = (r_state == S_RUN) & ~w_empty[i] & (~r_valid[i] | instr_ack[i]) & ~abort;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE:  if (process_iseq) w_state_nxt = S_RUN;
      S_RUN: begin
        if (abort) w_state_nxt = S_IDLE;
        else if ((&w_empty) && (w_rd == '0)) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (abort) w_state_nxt = S_IDLE;
        else if (!(&w_empty)) w_state_nxt = S_RUN;
        else if (r_valid == '0) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
      r_valid <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= w_done_nxt;
      if (!w_active) begin
        if (process_iseq) r_cnt <= '0;
      end else begin
        r_cnt <= sat_add(r_cnt, popcnt(r_valid & instr_ack));
      end
      // Refill wins over ack so an acked lane can reload in the same cycle.
      for (int i = 0; i < N_LANES; i++) begin
        if (abort && w_active) begin
          r_valid[i] <= 1'b0;
        end else if (w_rd[i]) begin
          r_valid[i]                    <= 1'b1;
          r_data[i*INSTR_W +: INSTR_W]  <= fifo_data[i*INSTR_W +: INSTR_W];
        end else if (instr_ack[i]) begin
          r_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign fifo_rd         = w_rd;
  assign instr_valid     = r_valid;
  assign instr_data      = r_data;
  assign issued_cnt      = r_cnt;
  assign dispatcher_busy = r_busy;
  assign iseq_done       = r_done;

endmodule

// File: tb/tb_iseq_dispatcher_nlane.sv
// Scoreboard bench for iseq_dispatcher_nlane (2 lanes, 4-bit issue counter).
module tb_iseq_dispatcher_nlane;

  localparam int NL = 2;
  localparam int IW = 32;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst, process_iseq, abort;
  logic            dispatcher_busy, iseq_done;
  logic [CW-1:0]   issued_cnt;
  logic [NL-1:0]   fifo_empty, fifo_rd, instr_valid, instr_ack;
  logic [NL*IW-1:0] fifo_data, instr_data;
`ifdef ISEQ_LANE_MASK_EN
  logic [NL-1:0]   lane_mask;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int n_acc;
  int n_done;
  bit v1_seen;

  logic [IW-1:0] fq0[$], fq1[$], eq0[$], eq1[$];

  iseq_dispatcher_nlane #(.N_LANES(NL), .INSTR_W(IW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .process_iseq(process_iseq), .abort(abort),
    .dispatcher_busy(dispatcher_busy), .iseq_done(iseq_done), .issued_cnt(issued_cnt),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd(fifo_rd),
    .instr_valid(instr_valid), .instr_data(instr_data), .instr_ack(instr_ack)
`ifdef ISEQ_LANE_MASK_EN
    , .lane_mask(lane_mask)
`endif
  );

  always #5 clk = ~clk;

  task automatic update_fifo_inputs();
    fifo_empty[0]      = (fq0.size() == 0);
    fifo_empty[1]      = (fq1.size() == 0);
    fifo_data[IW-1:0]  = (fq0.size() != 0) ? fq0[0] : '0;
    fifo_data[2*IW-1:IW] = (fq1.size() != 0) ? fq1[0] : '0;
  endtask

  task automatic push(input int lane, input logic [IW-1:0] w);
    if (lane == 0) begin fq0.push_back(w); eq0.push_back(w); end
    else           begin fq1.push_back(w); eq1.push_back(w); end
    update_fifo_inputs();
  endtask

  task automatic clear_queues();
    fq0.delete(); fq1.delete(); eq0.delete(); eq1.delete();
    update_fifo_inputs();
  endtask

  // One clock: scoreboard accepted words at negedge, then retire popped FIFO words after the edge.
  task automatic step();
    logic [NL-1:0] rd_s, acc;
    logic [IW-1:0] exp_w;
    @(negedge clk);
    rd_s = fifo_rd;
    acc  = instr_valid & instr_ack;
    if (iseq_done) n_done++;
    if (instr_valid[1]) v1_seen = 1'b1;
    for (int l = 0; l < NL; l++) begin
      if (acc[l]) begin
        n_acc++;
        n_checks++;
        if ((l == 0 && eq0.size() == 0) || (l == 1 && eq1.size() == 0)) begin
          n_errors++;
          $display("FAIL accept_lane%0d: got 0x%08h, expected no word", l, instr_data[l*IW +: IW]);
        end else begin
          exp_w = (l == 0) ? eq0.pop_front() : eq1.pop_front();
          if (instr_data[l*IW +: IW] !== exp_w) begin
            n_errors++;
            $display("FAIL data_lane%0d: got 0x%08h, expected 0x%08h", l, instr_data[l*IW +: IW], exp_w);
          end
        end
      end
    end
    @(posedge clk);
    #1;
    if (rd_s[0] && fq0.size() != 0) void'(fq0.pop_front());
    if (rd_s[1] && fq1.size() != 0) void'(fq1.pop_front());
    update_fifo_inputs();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1; process_iseq = 1'b0; abort = 1'b0; instr_ack = '0;
`ifdef ISEQ_LANE_MASK_EN
    lane_mask = '1;
`endif
    clear_queues();
    run(2);
    rst = 1'b0;
    n_acc = 0; n_done = 0; v1_seen = 1'b0;
  endtask

  task automatic start();
    process_iseq = 1'b1;
    step();
    process_iseq = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({dispatcher_busy, iseq_done, issued_cnt, fifo_rd, instr_valid} !== '0 || instr_data !== '0) begin
      n_errors++;
      $display("FAIL reset: busy=%0b done=%0b cnt=%0d rd=%b valid=%b data=0x%h, expected all zero",
               dispatcher_busy, iseq_done, issued_cnt, fifo_rd, instr_valid, instr_data);
    end
  endtask

  task automatic test_basic_run();
    do_reset();
    for (int k = 0; k < 4; k++) push(0, 32'h1000_0000 + k);
    for (int k = 0; k < 3; k++) push(1, 32'h2000_0000 + k);
    instr_ack = 2'b11;
    start();
    n_checks++;
    if (dispatcher_busy !== 1'b1) begin
      n_errors++; $display("FAIL basic_busy_rise: got %0b, expected 1", dispatcher_busy);
    end
    run(30);
    n_checks++;
    if (n_acc != 7) begin n_errors++; $display("FAIL basic_accepts: got %0d, expected 7", n_acc); end
    n_checks++;
    if (issued_cnt !== 4'd7) begin n_errors++; $display("FAIL basic_cnt: got %0d, expected 7", issued_cnt); end
    n_checks++;
    if (n_done != 1) begin n_errors++; $display("FAIL basic_done: got %0d pulses, expected 1", n_done); end
    n_checks++;
    if (dispatcher_busy !== 1'b0) begin n_errors++; $display("FAIL basic_busy_fall: got %0b, expected 0", dispatcher_busy); end
  endtask

  task automatic test_backpressure();
    int acc1_before;
    do_reset();
    for (int k = 0; k < 3; k++) push(0, 32'hA000_0000 + k);
    for (int k = 0; k < 3; k++) push(1, 32'hB000_0000 + k);
    instr_ack = 2'b10;
    start();
    run(1);
    acc1_before = n_acc;
    for (int k = 0; k < 5; k++) begin
      step();
      n_checks++;
      if (instr_valid[0] !== 1'b1 || instr_data[IW-1:0] !== 32'hA000_0000 || fifo_rd[0] !== 1'b0) begin
        n_errors++;
        $display("FAIL hold_lane0 cyc%0d: valid=%0b data=0x%08h rd=%0b, expected 1/0xa0000000/0",
                 k, instr_valid[0], instr_data[IW-1:0], fifo_rd[0]);
      end
    end
    n_checks++;
    if (n_acc - acc1_before != 3) begin
      n_errors++; $display("FAIL hold_lane1_flow: got %0d lane1 accepts, expected 3", n_acc - acc1_before);
    end
    instr_ack = 2'b11;
    run(20);
    n_checks++;
    if (n_acc != 6 || n_done != 1) begin
      n_errors++; $display("FAIL hold_finish: accepts=%0d done=%0d, expected 6/1", n_acc, n_done);
    end
  endtask

  task automatic test_abort();
    do_reset();
    for (int k = 0; k < 3; k++) push(0, 32'hC000_0000 + k);
    for (int k = 0; k < 3; k++) push(1, 32'hD000_0000 + k);
    instr_ack = 2'b11;
    start();
    run(1);
    abort = 1'b1;
    #1;
    n_checks++;
    if (fifo_rd !== 2'b00) begin n_errors++; $display("FAIL abort_rd: got %b, expected 00", fifo_rd); end
    step();
    abort = 1'b0;
    n_checks++;
    if (instr_valid !== 2'b00 || dispatcher_busy !== 1'b0) begin
      n_errors++; $display("FAIL abort_flush: valid=%b busy=%0b, expected 00/0", instr_valid, dispatcher_busy);
    end
    run(5);
    n_checks++;
    if (fq0.size() != 2 || fq1.size() != 2 || n_done != 0) begin
      n_errors++;
      $display("FAIL abort_idle: fifo0=%0d fifo1=%0d done=%0d, expected 2/2/0", fq0.size(), fq1.size(), n_done);
    end
  endtask

  task automatic test_drain_reentry();
    do_reset();
    push(0, 32'hE000_0000);
    instr_ack = 2'b00;
    start();
    run(2);
    push(1, 32'hF000_0001);
    step();
    n_checks++;
    if (fifo_rd[1] !== 1'b1 || dispatcher_busy !== 1'b1) begin
      n_errors++; $display("FAIL drain_reentry: rd1=%0b busy=%0b, expected 1/1", fifo_rd[1], dispatcher_busy);
    end
    instr_ack = 2'b11;
    run(15);
    n_checks++;
    if (n_acc != 2 || n_done != 1 || issued_cnt !== 4'd2) begin
      n_errors++;
      $display("FAIL drain_finish: accepts=%0d done=%0d cnt=%0d, expected 2/1/2", n_acc, n_done, issued_cnt);
    end
  endtask

  task automatic test_saturation_and_rst();
    do_reset();
    for (int k = 0; k < 10; k++) begin
      push(0, 32'h5000_0000 + k);
      push(1, 32'h6000_0000 + k);
    end
    instr_ack = 2'b11;
    start();
    run(4);
    process_iseq = 1'b1;
    step();
    process_iseq = 1'b0;
    run(30);
    n_checks++;
    if (n_acc != 20 || issued_cnt !== 4'd15 || n_done != 1) begin
      n_errors++;
      $display("FAIL saturate: accepts=%0d cnt=%0d done=%0d, expected 20/15/1", n_acc, issued_cnt, n_done);
    end
    for (int k = 0; k < 4; k++) begin
      push(0, 32'h7000_0000 + k);
      push(1, 32'h8000_0000 + k);
    end
    start();
    run(2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_queues();
    #1;
    n_checks++;
    if ({dispatcher_busy, iseq_done, issued_cnt, fifo_rd, instr_valid} !== '0 || instr_data !== '0) begin
      n_errors++;
      $display("FAIL mid_rst: busy=%0b done=%0b cnt=%0d rd=%b valid=%b data=0x%h, expected all zero",
               dispatcher_busy, iseq_done, issued_cnt, fifo_rd, instr_valid, instr_data);
    end
  endtask

`ifdef ISEQ_LANE_MASK_EN
  task automatic test_lane_mask();
    do_reset();
    push(0, 32'h9000_0000); push(0, 32'h9000_0001);
    fq1.push_back(32'h9100_0000); fq1.push_back(32'h9100_0001);
    update_fifo_inputs();
    lane_mask = 2'b01;
    instr_ack = 2'b11;
    start();
    lane_mask = 2'b11;
    run(15);
    n_checks++;
    if (n_acc != 2 || n_done != 1 || fq1.size() != 2 || v1_seen) begin
      n_errors++;
      $display("FAIL lane_mask: accepts=%0d done=%0d fifo1=%0d v1=%0b, expected 2/1/2/0",
               n_acc, n_done, fq1.size(), v1_seen);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; process_iseq = 1'b0; abort = 1'b0; instr_ack = '0;
    fifo_empty = '1; fifo_data = '0;
`ifdef ISEQ_LANE_MASK_EN
    lane_mask = '1;
`endif
    test_reset();
    test_basic_run();
    test_backpressure();
    test_abort();
    test_drain_reentry();
    test_saturation_and_rst();
`ifdef ISEQ_LANE_MASK_EN
    test_lane_mask();
`endif
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
